// File: rtl/rf_pkg.sv
// Shared sizes and types for the register file and its write-back scoreboard.
package rf_pkg;

  localparam int unsigned REG_NUM = 32;
  localparam int unsigned REG_AW  = 5;
  localparam int unsigned DATA_W  = 32;
  localparam int unsigned SB_CW   = 2;

  typedef logic [REG_AW-1:0] reg_addr_t;
  typedef logic [DATA_W-1:0] data_t;
  typedef logic [SB_CW-1:0]  sb_cnt_t;

  // Saturation value of a per-register outstanding-write counter.
  localparam sb_cnt_t SbCntMax = '1;

  // True when a write-back hits a non-zero destination equal to the read address.
  function automatic logic fwd_hit(input logic wr_en, input reg_addr_t wr_addr,
                                   input reg_addr_t rd_addr);
    return wr_en && (wr_addr != '0) && (rd_addr == wr_addr);
  endfunction

endpackage

// File: rtl/regfile_if.sv
// Register file bus: write-back port, two read ports and scoreboard controls.
// master drives addresses/data/controls; slave (the register file) answers.
interface regfile_if;
  import rf_pkg::*;

  reg_addr_t i_RF_reg_RegAddrW;
  data_t     i_RF_reg_RegDataW;
  logic      i_RF_reg_RegWrite;
  reg_addr_t i_RF_rd_AddrA;
  reg_addr_t i_RF_rd_AddrB;
  logic      i_RF_sb_Set;
  reg_addr_t i_RF_sb_SetAddr;
  logic      i_RF_sb_Flush;
  data_t     o_RF_rd_DataA;
  data_t     o_RF_rd_DataB;
  logic      o_RF_sb_BusyA;
  logic      o_RF_sb_BusyB;
  logic      o_RF_sb_Overflow;

  modport master (
    output i_RF_reg_RegAddrW, i_RF_reg_RegDataW, i_RF_reg_RegWrite,
    output i_RF_rd_AddrA, i_RF_rd_AddrB,
    output i_RF_sb_Set, i_RF_sb_SetAddr, i_RF_sb_Flush,
    input  o_RF_rd_DataA, o_RF_rd_DataB,
    input  o_RF_sb_BusyA, o_RF_sb_BusyB, o_RF_sb_Overflow
  );

  modport slave (
    input  i_RF_reg_RegAddrW, i_RF_reg_RegDataW, i_RF_reg_RegWrite,
    input  i_RF_rd_AddrA, i_RF_rd_AddrB,
    input  i_RF_sb_Set, i_RF_sb_SetAddr, i_RF_sb_Flush,
    output o_RF_rd_DataA, o_RF_rd_DataB,
    output o_RF_sb_BusyA, o_RF_sb_BusyB, o_RF_sb_Overflow
  );

endinterface

// File: rtl/regfile_sb.sv
// Write-back scoreboard: a saturating 2-bit outstanding-write counter per register,
// Busy flags for both read addresses and a sticky overflow flag.
// Optional feature: define REGFILE_BYPASS_EN so a register whose last outstanding write
// is being written back this cycle no longer reads as busy.
module regfile_sb
  import rf_pkg::*;
(
  input  logic      clk,
  input  logic      nrst,
  input  logic      set,
  input  reg_addr_t set_addr,
  input  logic      flush,
  input  logic      wb_en,
  input  reg_addr_t wb_addr,
  input  reg_addr_t addr_a,
  input  reg_addr_t addr_b,
  output logic      busy_a,
  output logic      busy_b,
  output logic      overflow
);

  sb_cnt_t cnt_q [REG_NUM];
  sb_cnt_t cnt_d [REG_NUM];
  logic    ovf_q, ovf_d;
  logic    inc [REG_NUM];
  logic    dec [REG_NUM];

  // Decode issue and write-back per register; register 0 never counts issues.
  always_comb begin
    for (int r = 0; r < REG_NUM; r++) begin
      inc[r] = set && (r != 0) && (set_addr == reg_addr_t'(r));
      dec[r] = wb_en && (wb_addr == reg_addr_t'(r));
    end
  end

  // Next counter values: flush wins, issue+retire cancel, saturate high, clamp at zero.
  always_comb begin
    ovf_d = ovf_q;
    for (int r = 0; r < REG_NUM; r++) begin
      cnt_d[r] = cnt_q[r];
      if (flush) begin
        cnt_d[r] = '0;
      end else if (inc[r] && !dec[r]) begin
        if (cnt_q[r] == SbCntMax) begin
          ovf_d = 1'b1;
        end else begin
          cnt_d[r] = cnt_q[r] + sb_cnt_t'(1);
        end
      end else if (dec[r] && !inc[r] && (cnt_q[r] != '0)) begin
        cnt_d[r] = cnt_q[r] - sb_cnt_t'(1);
      end
    end
  end

  // Counter and sticky overflow state.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      for (int r = 0; r < REG_NUM; r++) begin
        cnt_q[r] <= '0;
      end
      ovf_q <= 1'b0;
    end else begin
      for (int r = 0; r < REG_NUM; r++) begin
        cnt_q[r] <= cnt_d[r];
      end
      ovf_q <= ovf_d;
    end
  end

  // Busy flags from the pre-edge counters, optionally hiding a retiring last write.
  always_comb begin
    busy_a = (addr_a != '0) && (cnt_q[addr_a] != '0);
    busy_b = (addr_b != '0) && (cnt_q[addr_b] != '0);
`ifdef REGFILE_BYPASS_EN
    if (fwd_hit(wb_en, wb_addr, addr_a) && (cnt_q[addr_a] == sb_cnt_t'(1))) begin
      busy_a = 1'b0;
    end
    if (fwd_hit(wb_en, wb_addr, addr_b) && (cnt_q[addr_b] == sb_cnt_t'(1))) begin
      busy_b = 1'b0;
    end
`endif
  end

  assign overflow = ovf_q;

endmodule

// File: rtl/regfile.sv
// 32 x 32-bit register file with two combinational read ports, one write-back port
// and an outstanding-write scoreboard (regfile_sb). Register 0 is hard-wired to zero.
// Optional feature: define REGFILE_BYPASS_EN for write-through forwarding of the
// write-back data onto a read port addressing the same register.
module regfile
  import rf_pkg::*;
(
  input logic       clk,
  input logic       nrst,
  regfile_if.slave  bus
);

  data_t regs_q [REG_NUM];
  data_t rd_a, rd_b;

  // Register storage; entry 0 is reset and never written so it always reads zero.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      for (int r = 0; r < REG_NUM; r++) begin
        regs_q[r] <= '0;
      end
    end else if (bus.i_RF_reg_RegWrite && (bus.i_RF_reg_RegAddrW != '0)) begin
      regs_q[bus.i_RF_reg_RegAddrW] <= bus.i_RF_reg_RegDataW;
    end
  end

  // Read muxes; forwarding is suppressed during reset so outputs read zero.
  always_comb begin
    rd_a = regs_q[bus.i_RF_rd_AddrA];
    rd_b = regs_q[bus.i_RF_rd_AddrB];
`ifdef REGFILE_BYPASS_EN
    if (nrst && fwd_hit(bus.i_RF_reg_RegWrite, bus.i_RF_reg_RegAddrW, bus.i_RF_rd_AddrA)) begin
      rd_a = bus.i_RF_reg_RegDataW;
    end
    if (nrst && fwd_hit(bus.i_RF_reg_RegWrite, bus.i_RF_reg_RegAddrW, bus.i_RF_rd_AddrB)) begin
      rd_b = bus.i_RF_reg_RegDataW;
    end
`endif
  end

  assign bus.o_RF_rd_DataA = rd_a;
  assign bus.o_RF_rd_DataB = rd_b;

  regfile_sb u_sb (
    .clk      (clk),
    .nrst     (nrst),
    .set      (bus.i_RF_sb_Set),
    .set_addr (bus.i_RF_sb_SetAddr),
    .flush    (bus.i_RF_sb_Flush),
    .wb_en    (bus.i_RF_reg_RegWrite),
    .wb_addr  (bus.i_RF_reg_RegAddrW),
    .addr_a   (bus.i_RF_rd_AddrA),
    .addr_b   (bus.i_RF_rd_AddrB),
    .busy_a   (bus.o_RF_sb_BusyA),
    .busy_b   (bus.o_RF_sb_BusyB),
    .overflow (bus.o_RF_sb_Overflow)
  );

endmodule

// File: tb/tb_regfile.sv
// Self-checking bench for regfile: directed scenarios plus randomized traffic compared
// against an array-based reference model. Works with or without REGFILE_BYPASS_EN.
module tb_regfile;
  import rf_pkg::*;

`ifdef REGFILE_BYPASS_EN
  localparam bit Bypass = 1'b1;
`else
  localparam bit Bypass = 1'b0;
`endif

  logic clk = 1'b0;
  logic nrst;

  regfile_if bus ();

  regfile dut (
    .clk  (clk),
    .nrst (nrst),
    .bus  (bus.slave)
  );

  always #5 clk = ~clk;

  int unsigned n_vec = 0;
  int unsigned n_err = 0;

  // Reference model: register contents, outstanding-write counts, sticky overflow.
  logic [31:0] m_regs [32];
  int          m_cnt  [32];
  bit          m_ovf;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %08h, expected %08h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int r = 0; r < 32; r++) begin
      m_regs[r] = '0;
      m_cnt[r]  = 0;
    end
    m_ovf = 1'b0;
  endtask

  function automatic bit hit(input int addr);
    return Bypass && bus.i_RF_reg_RegWrite && (int'(bus.i_RF_reg_RegAddrW) != 0) &&
           (addr == int'(bus.i_RF_reg_RegAddrW));
  endfunction

  function automatic logic [31:0] exp_rd(input int addr);
    if (!nrst) return '0;
    if (hit(addr)) return bus.i_RF_reg_RegDataW;
    return m_regs[addr];
  endfunction

  function automatic logic exp_busy(input int addr);
    if (addr == 0) return 1'b0;
    if (hit(addr) && m_cnt[addr] == 1) return 1'b0;
    return m_cnt[addr] != 0;
  endfunction

  // Apply the effect of one rising edge using the currently driven inputs.
  task automatic model_edge();
    int wa, sa, d;
    wa = int'(bus.i_RF_reg_RegAddrW);
    sa = int'(bus.i_RF_sb_SetAddr);
    if (bus.i_RF_sb_Flush) begin
      for (int r = 0; r < 32; r++) m_cnt[r] = 0;
    end else begin
      for (int r = 1; r < 32; r++) begin
        d = 0;
        if (bus.i_RF_sb_Set && sa == r) d = d + 1;
        if (bus.i_RF_reg_RegWrite && wa == r) d = d - 1;
        if (d == 1) begin
          if (m_cnt[r] == 3) m_ovf = 1'b1;
          else m_cnt[r] = m_cnt[r] + 1;
        end else if (d == -1 && m_cnt[r] > 0) begin
          m_cnt[r] = m_cnt[r] - 1;
        end
      end
    end
    if (bus.i_RF_reg_RegWrite && wa != 0) m_regs[wa] = bus.i_RF_reg_RegDataW;
  endtask

  task automatic check_outputs(input string tag);
    int ra, rb;
    ra = int'(bus.i_RF_rd_AddrA);
    rb = int'(bus.i_RF_rd_AddrB);
    check_val({tag, ".dataA"}, bus.o_RF_rd_DataA, exp_rd(ra));
    check_val({tag, ".dataB"}, bus.o_RF_rd_DataB, exp_rd(rb));
    check_val({tag, ".busyA"}, 32'(bus.o_RF_sb_BusyA), 32'(exp_busy(ra)));
    check_val({tag, ".busyB"}, 32'(bus.o_RF_sb_BusyB), 32'(exp_busy(rb)));
    check_val({tag, ".ovf"}, 32'(bus.o_RF_sb_Overflow), 32'(m_ovf));
  endtask

  task automatic drive(input logic we, input int wa, input logic [31:0] wd, input int ra,
                       input int rb, input logic set, input int sa, input logic fl);
    bus.i_RF_reg_RegWrite = we;
    bus.i_RF_reg_RegAddrW = reg_addr_t'(wa);
    bus.i_RF_reg_RegDataW = wd;
    bus.i_RF_rd_AddrA     = reg_addr_t'(ra);
    bus.i_RF_rd_AddrB     = reg_addr_t'(rb);
    bus.i_RF_sb_Set       = set;
    bus.i_RF_sb_SetAddr   = reg_addr_t'(sa);
    bus.i_RF_sb_Flush     = fl;
  endtask

  // Drive mid-cycle and compare combinational outputs before the next edge.
  task automatic apply(input string tag, input logic we, input int wa, input logic [31:0] wd,
                       input int ra, input int rb, input logic set, input int sa,
                       input logic fl);
    @(negedge clk);
    drive(we, wa, wd, ra, rb, set, sa, fl);
    #1;
    check_outputs(tag);
  endtask

  task automatic tick();
    @(posedge clk);
    if (nrst) model_edge();
  endtask

  task automatic cycle(input string tag, input logic we, input int wa, input logic [31:0] wd,
                       input int ra, input int rb, input logic set, input int sa,
                       input logic fl);
    apply(tag, we, wa, wd, ra, rb, set, sa, fl);
    tick();
  endtask

  task automatic idle(input string tag, input int ra, input int rb);
    cycle(tag, 1'b0, 0, '0, ra, rb, 1'b0, 0, 1'b0);
  endtask

  // Reset asserted between edges with a write and a Set pending; held across one edge.
  task automatic pulse_reset(input string tag);
    @(negedge clk);
    drive(1'b1, 5, $urandom, 5, 9, 1'b1, 9, 1'b0);
    #1;
    nrst = 1'b0;
    #1;
    model_reset();
    check_outputs(tag);
    @(posedge clk);
    #2;
    check_outputs({tag, ".held"});
    nrst = 1'b1;
  endtask

  initial begin
    logic [31:0] wd;
    nrst = 1'b0;
    drive(1'b0, 0, '0, 0, 0, 1'b0, 0, 1'b0);
    model_reset();
    repeat (2) @(negedge clk);
    #1;
    check_outputs("por");
    nrst = 1'b1;

    // All addresses read zero after reset.
    for (int i = 0; i < 32; i++) idle("rst_read", i, 31 - i);

    // Write r5, attempt write to r0.
    cycle("wr5", 1'b1, 5, 32'hDEADBEEF, 5, 0, 1'b0, 0, 1'b0);
    cycle("wr0", 1'b1, 0, 32'h12345678, 5, 0, 1'b0, 0, 1'b0);
    apply("rd5", 1'b0, 0, '0, 5, 0, 1'b0, 0, 1'b0);
    check_val("r5_value", bus.o_RF_rd_DataA, 32'hDEADBEEF);
    check_val("r0_value", bus.o_RF_rd_DataB, 32'h0);
    tick();

    // Same-cycle write and read of r7 (r7 holds 0 before).
    apply("wr7", 1'b1, 7, 32'hA5A5A5A5, 7, 7, 1'b0, 0, 1'b0);
    check_val("r7_fwd", bus.o_RF_rd_DataA, Bypass ? 32'hA5A5A5A5 : 32'h0);
    tick();

    // Two Sets to r3, then two write-backs; then Set+write-back together.
    cycle("set3a", 1'b0, 0, '0, 3, 0, 1'b1, 3, 1'b0);
    apply("set3b", 1'b0, 0, '0, 3, 0, 1'b1, 3, 1'b0);
    check_val("r3_busy1", 32'(bus.o_RF_sb_BusyA), 32'd1);
    tick();
    apply("wb3a", 1'b1, 3, 32'h3333_0001, 3, 0, 1'b0, 0, 1'b0);
    check_val("r3_busy2", 32'(bus.o_RF_sb_BusyA), 32'd1);
    tick();
    apply("wb3b", 1'b1, 3, 32'h3333_0002, 3, 0, 1'b0, 0, 1'b0);
    check_val("r3_busy3", 32'(bus.o_RF_sb_BusyA), Bypass ? 32'd0 : 32'd1);
    tick();
    apply("r3_idle", 1'b0, 0, '0, 3, 0, 1'b0, 0, 1'b0);
    check_val("r3_free", 32'(bus.o_RF_sb_BusyA), 32'd0);
    tick();
    cycle("set3c", 1'b0, 0, '0, 3, 0, 1'b1, 3, 1'b0);
    cycle("setwb3", 1'b1, 3, 32'h3333_0003, 3, 0, 1'b1, 3, 1'b0);
    apply("r3_keep", 1'b0, 0, '0, 3, 0, 1'b0, 0, 1'b0);
    check_val("r3_unchanged", 32'(bus.o_RF_sb_BusyA), 32'd1);
    tick();
    cycle("wb3c", 1'b1, 3, 32'h3333_0004, 3, 0, 1'b0, 0, 1'b0);

    // Saturation on r9, overflow survives flush, cleared only by reset.
    for (int i = 0; i < 4; i++) cycle("set9", 1'b0, 0, '0, 9, 3, 1'b1, 9, 1'b0);
    apply("ovf_chk", 1'b0, 0, '0, 9, 3, 1'b0, 0, 1'b0);
    check_val("ovf_set", 32'(bus.o_RF_sb_Overflow), 32'd1);
    tick();
    cycle("flush9", 1'b0, 0, '0, 9, 3, 1'b0, 0, 1'b1);
    apply("ovf_flush", 1'b0, 0, '0, 9, 3, 1'b0, 0, 1'b0);
    check_val("ovf_sticky", 32'(bus.o_RF_sb_Overflow), 32'd1);
    check_val("r9_flushed", 32'(bus.o_RF_sb_BusyA), 32'd0);
    tick();
    pulse_reset("rst_ovf");
    apply("ovf_clr", 1'b0, 0, '0, 5, 7, 1'b0, 0, 1'b0);
    check_val("ovf_cleared", 32'(bus.o_RF_sb_Overflow), 32'd0);
    tick();

    // Flush overrides a simultaneous Set.
    cycle("set4", 1'b0, 0, '0, 4, 6, 1'b1, 4, 1'b0);
    cycle("set6", 1'b0, 0, '0, 4, 6, 1'b1, 6, 1'b0);
    cycle("flush8", 1'b0, 0, '0, 4, 6, 1'b1, 8, 1'b1);
    apply("post_flush", 1'b0, 0, '0, 4, 8, 1'b0, 0, 1'b0);
    check_val("r4_flushed", 32'(bus.o_RF_sb_BusyA), 32'd0);
    check_val("r8_flushed", 32'(bus.o_RF_sb_BusyB), 32'd0);
    tick();
    cycle("wr5b", 1'b1, 5, 32'hCAFE0005, 5, 6, 1'b1, 6, 1'b0);
    pulse_reset("rst_mid");

    // Randomized traffic, addresses biased low so counters interact.
    for (int n = 0; n < 3000; n++) begin
      int wa, sa;
      wa = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 31)) : int'($urandom_range(0, 5));
      sa = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 31)) : int'($urandom_range(0, 5));
      wd = $urandom;
      if ($urandom_range(0, 499) == 0) begin
        pulse_reset("rnd_rst");
      end else begin
        cycle("rnd", 1'($urandom_range(0, 1)), wa, wd,
              ($urandom_range(0, 1) == 0) ? wa : int'($urandom_range(0, 7)),
              ($urandom_range(0, 1) == 0) ? sa : int'($urandom_range(0, 31)),
              1'($urandom_range(0, 2) != 0), sa, 1'($urandom_range(0, 40) == 0));
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
